cache_fill_controller: RTL and testbench
========================================

// Module: cache_fill_controller
// PURPOSE
//  Miss-handling sequencer for one cache (I or D) built on the 128-block x 8-word data array.
//  On a miss, issues 8 sequential word reads to main memory and steers returning words into the array.
//  Drives data array write / word enable and the tag array write; stalls the pipeline while busy.
//  Sits between the cache hit logic and the shared memory port arbiter.
// PARAMETERS
//  WORDS        8   words per cache block; fixed at 8, counters are 3 bits.
//  ADDR_W      16   byte address width.
//  OFFSET_BITS  4   block offset bits: 16 bytes per block, word select = addr[3:1].
// PORTS
//  clk                input   1   system clock, rising edge.
//  rst                input   1   asynchronous, active-high reset.
//  miss_detected      input   1   cache lookup missed this cycle (level).
//  miss_address       input  16   byte address of the missing access.
//  memory_data        input  16   word returned by memory.
//  memory_data_valid  input   1   memory_data valid this cycle, in issue order.
//  fsm_busy           output  1   fill in progress; the pipeline stalls on it.
//  memory_read        output  1   memory read request this cycle.
//  memory_address     output 16   word-aligned byte address of the request.
//  write_data_array   output  1   write memory_data into the array this cycle.
//  word_enable        output  8   one-hot word select for the data array write.
//  write_tag_array    output  1   write the tag / set valid for the filled block (1 cycle).
//  fill_done          output  1   1-cycle pulse: last word written.
// BEHAVIOUR
//  Reset (async): state=IDLE, issue_cnt=0, recv_cnt=0, base=0; every output 0.
//  States: IDLE, FILL. Encoding is 1 bit.
//  IDLE:
//   - miss_detected=1: latch base={miss_address[15:4],4'b0}; clear both counters; go to FILL next edge.
//   - memory_data_valid in IDLE is ignored (no write).
//  FILL:
//   - fsm_busy=1 for the whole state (registered from state).
//   - Issue path: memory_read=1 while issue_done=0.
//     memory_address=base+{issue_cnt,1'b0}. issue_cnt increments each FILL cycle.
//     issue_done sets when 8 requests have gone out (issue_cnt wraps 7->0). 8 requests on 8 consecutive cycles.
//   - Receive path (combinational on input):
//     write_data_array=memory_data_valid; word_enable=memory_data_valid ? (8'b1<<recv_cnt) : 8'b0.
//     recv_cnt increments on each valid.
//   - Last word: valid with recv_cnt==7 asserts write_tag_array=1 and fill_done=1 in that cycle.
//     Next edge: IDLE, fsm_busy=0.
//   - miss_detected while in FILL is ignored; base is frozen.
//  Latency: memory latency is arbitrary (>=1 cycle); the block counts valids and never times out.
//   With 4-cycle memory: busy for 12 cycles (miss edge -> 4th cycle after last issue).
//  Simultaneous events: issue and receive in the same cycle are independent.
//   fill_done in the same cycle as a new miss_detected: the new miss is taken only after return to IDLE.
//  Address arithmetic: offset add is 4-bit within the block; tag/index bits never change; no carry out.
//  Reset mid-fill: abort immediately, outputs 0, no tag write; the partially filled block stays invalid.
// STRUCTURE
//  Shared package (cache_pkg): state encoding (IDLE/FILL), WORDS, OFFSET_BITS, BLOCK_BYTES.
//  Sub-module fill_counter: 3-bit up counter, inputs clk, rst, clr, inc; outputs cnt, wrap (cnt==7 & inc).
//   Instantiated twice (issue, receive).
//  Control FSM, output decode and base register live in the top module.
// TESTING
//  1 Reset: assert rst mid-cycle -> all outputs 0 immediately (async), state IDLE.
//  2 Basic fill: miss_address=16'h1234, memory latency 4
//    -> memory_address 1230,1232,...,123E over 8 cycles.
//    -> word_enable 01,02,...,80 on the valids.
//    -> write_tag_array and fill_done with word_enable=80; fsm_busy low the next cycle.
//  3 Stray data: memory_data_valid=1 in IDLE -> write_data_array=0, word_enable=0.
//  4 Miss while busy: pulse miss_detected with 16'hABC0 during the fill of 16'h1230
//    -> addresses stay 123x; after fill_done, holding miss high starts the ABC0 fill.
//  5 Abort: assert rst after the 3rd valid -> no tag write; next miss 16'h0040 restarts at word 0, 0040.
//  6 Gapped returns: valids with random gaps (latency 1..10) -> exactly 8 array writes, in order.
//    One tag write; busy never drops early.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and constants for the cache fill sequencer
package cache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  localparam int WORDS       = 8;
  localparam int ADDR_W      = 16;
  localparam int OFFSET_BITS = 4;
  localparam int BLOCK_BYTES = 16;
  localparam int CNT_W       = 3;
  localparam int TAG_IDX_W   = ADDR_W - OFFSET_BITS;

endpackage

// File: rtl/fill_counter.sv
// rtl/fill_counter.sv - 3-bit word counter with clear and wrap strobe
module fill_counter
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = inc && (cnt_q == 3'd7);

endmodule

// File: rtl/cache_fill_controller.sv
// rtl/cache_fill_controller.sv - miss fill sequencer: issues 8 word reads and steers returns into the array
module cache_fill_controller
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic [15:0] memory_data,
  input  logic        memory_data_valid,
  output logic        fsm_busy,
  output logic        memory_read,
  output logic [15:0] memory_address,
  output logic        write_data_array,
  output logic [7:0]  word_enable,
  output logic        write_tag_array,
  output logic        fill_done
);

  fill_state_t          state_q, state_d;
  logic [TAG_IDX_W-1:0] base_q, base_d;
  logic                 issue_done_q, issue_done_d;

  logic             in_fill;
  logic             start_fill;
  logic             recv_inc;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] recv_cnt;
  logic             issue_wrap;
  logic             recv_wrap;

  // Data goes straight to the array; this block only decides when and where it lands.
  logic unused_bits;
  assign unused_bits = ^{memory_data, miss_address[OFFSET_BITS-1:0]};

  assign in_fill    = (state_q == FILL);
  assign start_fill = (state_q == IDLE) && miss_detected;
  assign recv_inc   = in_fill && memory_data_valid;

  fill_counter u_issue_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_fill),
    .inc  (memory_read),
    .cnt  (issue_cnt),
    .wrap (issue_wrap)
  );

  fill_counter u_recv_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_fill),
    .inc  (recv_inc),
    .cnt  (recv_cnt),
    .wrap (recv_wrap)
  );

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    issue_done_d = issue_done_q;
    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          state_d      = FILL;
          base_d       = miss_address[ADDR_W-1:OFFSET_BITS];
          issue_done_d = 1'b0;
        end
      end
      FILL: begin
        if (issue_wrap) begin
          issue_done_d = 1'b1;
        end
        // A miss arriving on the last-word cycle waits for IDLE.
        if (recv_wrap) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      base_q       <= '0;
      issue_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      issue_done_q <= issue_done_d;
    end
  end

  assign fsm_busy         = in_fill;
  assign memory_read      = in_fill && !issue_done_q;
  assign memory_address   = memory_read ? {base_q, issue_cnt, 1'b0} : 16'h0000;
  assign write_data_array = recv_inc;
  assign word_enable      = recv_inc ? (8'b0000_0001 << recv_cnt) : 8'b0000_0000;
  assign write_tag_array  = recv_wrap;
  assign fill_done        = recv_wrap;

endmodule

// File: tb/tb_cache_fill_controller.sv
// tb/tb_cache_fill_controller.sv - self-checking bench for cache_fill_controller
module tb_cache_fill_controller;

  logic        clk;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        memory_read;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [7:0]  word_enable;
  logic        write_tag_array;
  logic        fill_done;

  cache_fill_controller dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .memory_read       (memory_read),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .word_enable       (word_enable),
    .write_tag_array   (write_tag_array),
    .fill_done         (fill_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        miss;
    logic [15:0] addr;
    logic        valid;
    logic        busy;
    logic        rd;
    logic [15:0] maddr;
    logic        wr;
    logic [7:0]  we;
    logic        tag;
  } vec_t;

  vec_t tbl[15];

  // Reference model: a fill is just "base, words requested, words received".
  bit          m_busy;
  logic [15:0] m_base;
  int          m_issued;
  int          m_recv;
  int          mq[$];
  int          cyc;
  int          lat_lo, lat_hi;
  int          n_wr, n_tag;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, {15'd0, fsm_busy}, 16'd0);
    chk({nm, "_rd"}, {15'd0, memory_read}, 16'd0);
    chk({nm, "_addr"}, memory_address, 16'd0);
    chk({nm, "_wr"}, {15'd0, write_data_array}, 16'd0);
    chk({nm, "_we"}, {8'd0, word_enable}, 16'd0);
    chk({nm, "_tag"}, {15'd0, write_tag_array}, 16'd0);
    chk({nm, "_done"}, {15'd0, fill_done}, 16'd0);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    memory_data_valid = 1'b1;
    #1;
    chk_all_zero("reset");
    m_busy = 0;
    mq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    memory_data_valid = 1'b0;
  endtask

  task automatic step(input logic miss, input logic [15:0] a, input logic stray);
    logic        v;
    logic        e_rd, e_wr, e_tag;
    logic [15:0] e_addr;
    logic [7:0]  e_we;
    int          t;
    @(posedge clk);
    #1;
    v = 1'b0;
    if (mq.size() > 0 && mq[0] <= cyc) begin
      v = 1'b1;
      void'(mq.pop_front());
    end else if (stray && !m_busy && mq.size() == 0) begin
      v = 1'b1;
    end
    miss_detected     = miss;
    miss_address      = a;
    memory_data_valid = v;
    memory_data       = 16'($urandom);
    @(negedge clk);
    e_rd   = m_busy && (m_issued < 8);
    e_addr = e_rd ? (m_base + 16'(2 * m_issued)) : 16'h0000;
    e_wr   = m_busy && v;
    e_we   = e_wr ? 8'(1 << m_recv) : 8'h00;
    e_tag  = e_wr && (m_recv == 7);
    chk("busy", {15'd0, fsm_busy}, {15'd0, m_busy});
    chk("read", {15'd0, memory_read}, {15'd0, e_rd});
    chk("addr", memory_address, e_addr);
    chk("wr", {15'd0, write_data_array}, {15'd0, e_wr});
    chk("we", {8'd0, word_enable}, {8'd0, e_we});
    chk("tag", {15'd0, write_tag_array}, {15'd0, e_tag});
    chk("done", {15'd0, fill_done}, {15'd0, e_tag});
    if (write_data_array) n_wr++;
    if (write_tag_array) n_tag++;
    if (m_busy) begin
      if (e_rd) begin
        t = cyc + int'($urandom_range(lat_hi, lat_lo));
        if (mq.size() > 0 && t <= mq[$]) t = mq[$] + 1;
        mq.push_back(t);
        m_issued++;
      end
      if (v) m_recv++;
      if (m_recv == 8) m_busy = 0;
    end else if (miss) begin
      m_busy   = 1;
      m_base   = {a[15:4], 4'h0};
      m_issued = 0;
      m_recv   = 0;
    end
    cyc++;
  endtask

  task automatic drain(input int budget, input bit noise);
    int k;
    k = 0;
    while (m_busy && k < budget) begin
      step(noise ? 1'($urandom_range(1, 0)) : 1'b0, 16'($urandom), 1'b0);
      k++;
    end
    chk("drain_bound", {15'd0, m_busy}, 16'd0);
  endtask

  initial begin
    int k, wr0, tag0;
    logic [15:0] ra;
    rst = 1'b1;
    miss_detected = 1'b0;
    miss_address = 16'h0;
    memory_data = 16'h0;
    memory_data_valid = 1'b0;
    m_busy = 0; m_base = 0; m_issued = 0; m_recv = 0;
    cyc = 0; lat_lo = 4; lat_hi = 4; n_wr = 0; n_tag = 0;
    #1;
    chk_all_zero("por");

    // Basic fill of 1234 with 4-cycle memory, then stray data in IDLE.
    tbl[0] = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 8'h00, 1'b0};
    for (int r = 1; r <= 12; r++) begin
      int c;
      c = r - 1;
      tbl[r].miss  = 1'b0;
      tbl[r].addr  = 16'h0;
      tbl[r].valid = (c >= 4);
      tbl[r].busy  = 1'b1;
      tbl[r].rd    = (c < 8);
      tbl[r].maddr = (c < 8) ? 16'(16'h1230 + 2 * c) : 16'h0;
      tbl[r].wr    = (c >= 4);
      tbl[r].we    = (c >= 4) ? 8'(1 << (c - 4)) : 8'h00;
      tbl[r].tag   = (c == 11);
    end
    tbl[13] = '{1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 8'h00, 1'b0};
    tbl[14] = '{1'b0, 16'h5678, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 8'h00, 1'b0};

    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      miss_detected     = tbl[i].miss;
      miss_address      = tbl[i].addr;
      memory_data_valid = tbl[i].valid;
      memory_data       = 16'($urandom);
      @(negedge clk);
      chk($sformatf("tbl%0d_busy", i), {15'd0, fsm_busy}, {15'd0, tbl[i].busy});
      chk($sformatf("tbl%0d_rd", i), {15'd0, memory_read}, {15'd0, tbl[i].rd});
      chk($sformatf("tbl%0d_addr", i), memory_address, tbl[i].maddr);
      chk($sformatf("tbl%0d_wr", i), {15'd0, write_data_array}, {15'd0, tbl[i].wr});
      chk($sformatf("tbl%0d_we", i), {8'd0, word_enable}, {8'd0, tbl[i].we});
      chk($sformatf("tbl%0d_tag", i), {15'd0, write_tag_array}, {15'd0, tbl[i].tag});
      chk($sformatf("tbl%0d_done", i), {15'd0, fill_done}, {15'd0, tbl[i].tag});
    end
    do_reset();

    // Miss while busy: ABC0 pulse is ignored, then held miss starts ABC0 after fill_done.
    lat_lo = 2; lat_hi = 5;
    step(1'b1, 16'h1230, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'hABC0, 1'b0);
    k = 0;
    while (m_busy && k < 60) begin
      step(m_recv >= 6, 16'hABC0, 1'b0);
      k++;
    end
    chk("missbusy_bound", {15'd0, m_busy}, 16'd0);
    step(1'b1, 16'hABC0, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    chk("abc0_first_addr", memory_address, 16'hABC0);
    drain(80, 1'b0);

    // Abort after the third returned word.
    tag0 = n_tag;
    step(1'b1, 16'h1230, 1'b0);
    k = 0;
    while (m_recv < 3 && k < 40) begin
      step(1'b0, 16'h0, 1'b0);
      k++;
    end
    do_reset();
    chk("abort_no_tag", 16'(n_tag), 16'(tag0));
    step(1'b1, 16'h0040, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    chk("restart_addr", memory_address, 16'h0040);
    wr0 = n_wr;
    drain(80, 1'b0);
    chk("restart_tags", 16'(n_tag - tag0), 16'd1);

    // Random fills with gapped returns and miss noise.
    lat_lo = 1; lat_hi = 10;
    for (int f = 0; f < 8; f++) begin
      for (int s = 0; s < 3; s++) step(1'($urandom_range(1, 0)) & 1'b0, 16'h0, 1'($urandom_range(1, 0)));
      wr0 = n_wr;
      tag0 = n_tag;
      ra = 16'($urandom);
      step(1'b1, ra, 1'b0);
      drain(120, 1'b1);
      chk($sformatf("fill%0d_writes", f), 16'(n_wr - wr0), 16'd8);
      chk($sformatf("fill%0d_tags", f), 16'(n_tag - tag0), 16'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
